// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared op encodings and FSM states for the bit-serial ALU
package ula_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/ula_bit.sv
// rtl/ula_bit.sv - combinational 1-bit ALU slice
module ula_bit
    import ula_pkg::*;
(
    input  logic       x,
    input  logic       y,
    input  logic       c,
    input  logic [2:0] op,
    output logic       s,
    output logic       co
);

    // Carry chain always runs as a full adder; sum output selected by op
    always_comb begin
        co = (x & y) | (x & c) | (y & c);
        case (op)
            OP_AND:  s = x & y;
            OP_OR:   s = x | y;
            OP_ADD:  s = x ^ y ^ c;
            OP_XOR:  s = x ^ y;
            default: s = 1'b0;
        endcase
    end

endmodule

// File: rtl/ula_serial.sv
// rtl/ula_serial.sv - bit-serial ALU sequencer with start/done handshake
module ula_serial
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ainv,
    input  logic             binv,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_nxt;
    logic             ainv_q;
    logic             binv_q;
    logic [2:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             x;
    logic             y;
    logic             s;
    logic             co;
    logic             last_bit;

    // Operand bits are consumed LSB first from the shift registers
    assign x          = a_sh[0] ^ ainv_q;
    assign y          = b_sh[0] ^ binv_q;
    assign last_bit   = (cnt == LAST);
    assign result_nxt = {s, result_q[WIDTH-1:1]};

    ula_bit u_bit (
        .x  (x),
        .y  (y),
        .c  (carry),
        .op (op_q),
        .s  (s),
        .co (co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, serial shifting and final flag capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            ainv_q   <= 1'b0;
            binv_q   <= 1'b0;
            op_q     <= 3'd0;
            carry    <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        ainv_q <= ainv;
                        binv_q <= binv;
                        op_q   <= op;
                        carry  <= cin;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    result_q <= result_nxt;
                    carry    <= co;
                    if (last_bit) begin
                        cnt    <= '0;
                        cout_q <= co;
                        ovf_q  <= carry ^ co;
                        zero_q <= (result_nxt == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_ula_serial.sv
// tb/tb_ula_serial.sv - randomized self-checking bench for ula_serial
module tb_ula_serial;

    localparam int W = 8;
    localparam int P = W + 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ainv;
    logic         binv;
    logic         cin;
    logic [2:0]   op;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_checks = 0;
    int n_errors = 0;

    ula_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .ainv   (ainv),
        .binv   (binv),
        .cin    (cin),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word-level reference: returns {ovf, cout, result}
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mai, input logic mbi, input logic mci,
                                           input logic [2:0] mop);
        logic [W-1:0] xv;
        logic [W-1:0] yv;
        logic [W:0]   sumv;
        logic [W-1:0] lov;
        logic [W-1:0] r;
        logic         co;
        logic         cm;
        xv   = mai ? ~ma : ma;
        yv   = mbi ? ~mb : mb;
        sumv = {1'b0, xv} + {1'b0, yv} + (W+1)'(mci);
        lov  = {1'b0, xv[W-2:0]} + {1'b0, yv[W-2:0]} + W'(mci);
        co   = sumv[W];
        cm   = lov[W-1];
        case (mop)
            3'd0:    r = xv & yv;
            3'd1:    r = xv | yv;
            3'd2:    r = sumv[W-1:0];
            3'd3:    r = xv ^ yv;
            default: r = '0;
        endcase
        return {cm ^ co, co, r};
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tai, input logic tbi, input logic tci, input logic [2:0] top);
        logic [W+1:0] m;
        logic [W-1:0] held;
        int           n;
        int           busyc;
        logic         got;
        m = model(ta, tb, tai, tbi, tci, top);
        @(negedge clk);
        a = ta; b = tb; ainv = tai; binv = tbi; cin = tci; op = top; start = 1'b1;
        @(posedge clk);
        n = 0; busyc = 0; got = 1'b0;
        while (!got && n <= 4 * W) begin
            @(negedge clk);
            if (n == 0) begin
                start = 1'b0;
                a = W'($urandom); b = W'($urandom);
                ainv = 1'($urandom); binv = 1'($urandom); cin = 1'($urandom); op = 3'($urandom);
            end
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busyc++;
                @(posedge clk);
                n++;
            end
        end
        check({tag, ":done_seen"}, 32'(got), 32'd1);
        check({tag, ":latency"}, 32'(n + 1), 32'(W + 1));
        check({tag, ":busy_cycles"}, 32'(busyc), 32'(W));
        check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
        check({tag, ":result"}, 32'(result), 32'(m[W-1:0]));
        check({tag, ":cout"}, 32'(cout), 32'(m[W]));
        check({tag, ":ovf"}, 32'(ovf), 32'(m[W+1]));
        check({tag, ":zero"}, 32'(zero), 32'(m[W-1:0] == '0));
        held = result;
        @(negedge clk);
        check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ":result_held"}, 32'(result), 32'(held));
    endtask

    initial begin
        logic [W+1:0] expq[$];
        logic [W+1:0] e;
        int           dcount;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; ainv = 1'b0; binv = 1'b0; cin = 1'b0; op = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:result", 32'(result), 32'd0);
        check("reset:cout", 32'(cout), 32'd0);
        check("reset:ovf", 32'(ovf), 32'd0);
        check("reset:zero", 32'(zero), 32'd1);
        rst = 1'b0;

        run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 3'd2);
        check("add_ovf:const_result", 32'(result), 32'h80);
        check("add_ovf:const_ovf", 32'(ovf), 32'd1);
        run_op("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 3'd2);
        check("sub_borrow:const_result", 32'(result), 32'hFE);
        check("sub_borrow:const_cout", 32'(cout), 32'd0);
        run_op("sub_noborrow", 8'h07, 8'h05, 1'b0, 1'b1, 1'b1, 3'd2);
        check("sub_noborrow:const_result", 32'(result), 32'h02);
        check("sub_noborrow:const_cout", 32'(cout), 32'd1);
        run_op("and", 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd0);
        check("and:const_result", 32'(result), 32'h30);
        run_op("or", 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd1);
        check("or:const_result", 32'(result), 32'hFC);
        run_op("xor", 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd3);
        check("xor:const_result", 32'(result), 32'hCC);
        run_op("nor", 8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0, 3'd0);
        check("nor:const_result", 32'(result), 32'h03);
        run_op("op5", 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd5);
        check("op5:const_zero", 32'(zero), 32'd1);
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 3'd2);
        check("add_wrap:const_result", 32'(result), 32'h00);
        check("add_wrap:const_cout", 32'(cout), 32'd1);
        check("add_wrap:const_zero", 32'(zero), 32'd1);

        // start held high: accepted every P cycles, operands scrambled each cycle
        ainv = 1'b0; binv = 1'b0; cin = 1'b0; op = 3'd2;
        for (int t = 0; t < 3 * P; t++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); start = 1'b1;
            if (t % P == 0) expq.push_back(model(a, b, 1'b0, 1'b0, 1'b0, 3'd2));
            @(posedge clk);
            #1;
            check($sformatf("cont:done_t%0d", t), 32'(done), 32'(t % P == W));
            if (t % P == W && expq.size() > 0) begin
                e = expq.pop_front();
                check($sformatf("cont:result_t%0d", t), 32'(result), 32'(e[W-1:0]));
                check($sformatf("cont:cout_t%0d", t), 32'(cout), 32'(e[W]));
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);

        // reset asserted in the 4th RUN cycle aborts the operation
        @(negedge clk);
        a = 8'h55; b = 8'h11; ainv = 1'b0; binv = 1'b0; cin = 1'b0; op = 3'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:done", 32'(done), 32'd0);
        check("abort:result", 32'(result), 32'd0);
        check("abort:zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort:no_done", 32'(dcount), 32'd0);
        run_op("after_abort", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 3'd2);
        check("after_abort:const_result", 32'(result), 32'h30);

        for (int i = 0; i < 30; i++) begin
            run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 3'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
